sub_bytes_pipe: RTL and testbench
=================================

Name: sub_bytes_pipe

Overview:
Pipelined, parametrised AES SubBytes engine. Applies the forward S-box or the inverse S-box to LANES bytes per beat, selected per beat by a mode bit, under a valid/ready handshake with full backpressure. It replaces the single-byte combinational substitution inside the round datapath, which uses LANES=16 for a full state, and the key expander, which uses LANES=4 for one word.

Parameters:
LANES, 16, number of byte lanes substituted per beat (1..16)
STAGES, 2, register stages from input acceptance to output (legal values 1 or 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept a beat this cycle
in_inv  input  1  0 = forward S-box, 1 = inverse S-box for this beat
in_data  input  8*LANES  bytes; lane k = in_data[8k+7:8k]
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts the beat
out_inv  output  1  mode bit carried with the beat
out_data  output  8*LANES  substituted bytes, lane-aligned with in_data
occupancy  output  $clog2(STAGES+1)  number of beats currently held (0..STAGES)

Behaviour:
- Both are synchronous, single clock domain; rst is sampled on the rising clk edge.
- Reset values: out_valid=0, out_inv=0, out_data=0, occupancy=0. in_ready=1 in the first cycle after reset.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_data and in_inv are sampled only on an input transfer.
- Lane k output = SBOX(in byte k) if inv=0, INV_SBOX(in byte k) if inv=1. Both are the standard FIPS-197 tables. There is no cross-lane interaction.
- STAGES=1:
  - The lookup is registered directly into the output register.
  - Latency is 1 cycle from input transfer to out_valid.
- STAGES=2:
  - Stage 0 registers the raw bytes and mode with a valid bit.
  - Stage 1 (the output register) holds the looked-up bytes.
  - Latency is 2 cycles.
- Stage advance: each stage i loads from stage i-1 when stage i is empty or stage i is being drained that cycle; otherwise it holds. in_ready = stage 0 empty OR stage 0 advancing this cycle. This gives a combinational ready path and no bubbles: 1 beat/cycle is sustained while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_inv stay stable.
  - Stalls propagate back. in_ready=0 once all STAGES registers are full.
  - No beat is ever dropped or duplicated.
- A simultaneous input and output transfer while full (out_ready=1) is legal. The pipe shifts and occupancy is unchanged.
- occupancy per cycle = previous value + input transfer - output transfer. It never exceeds STAGES and never underflows.
- Mode switching: in_inv may differ on every beat. Each beat carries its own mode bit through the pipe, so mixed streams need no flush.
- Reset mid-operation:
  - All valid bits clear on the next edge and in-flight beats are discarded.
  - An input offered in the same cycle as rst=1 is not accepted.
- in_valid while in_ready=0: no transfer; the upstream must hold.
- Data registers need not be reset except the output register, which resets to 0 as stated.

Optional Feature:
SUBBYTES_BYPASS_EN.
- Defined:
  - Adds input port in_bypass (1 bit), carried per beat like in_inv, and output port out_bypass (1 bit) mirroring it.
  - A beat with in_bypass=1 passes in_data unchanged to out_data, with the same latency and handshake. This is used for the initial AddRoundKey-only path.
- Undefined: the ports are absent and every beat is substituted.

Test Plan:
- Forward substitution: LANES=4, STAGES=2; after rst, send in_inv=0, in_data=32'hfa65_5600 with out_ready=1 -> out_data=32'h2d4d_b163 exactly 2 cycles later, out_inv=0, occupancy back to 0.
- Inverse substitution: send in_inv=1, in_data=32'h2d4d_b163 -> out_data=32'hfa65_5600; then a back-to-back mixed stream alternating inv=0/1 -> each beat correct, 1 beat/cycle throughput.
- Backpressure: hold out_ready=0 and drive in_valid=1 continuously -> exactly STAGES beats accepted, in_ready=0, occupancy=2, out_data stable; release out_ready -> beats drain in order, none lost.
- Reset mid-stream: with the pipe full (occupancy=2), assert rst for 1 cycle -> next cycle out_valid=0, occupancy=0, in_ready=1, and no stale beat appears later.
- Exhaustive tables: LANES=16, STAGES=1; sweep all 256 byte values across lanes in both modes -> check every result against the FIPS-197 tables (e.g. 00->63, ff->16, inverse 63->00, 16->ff), with latency 1.
- Bypass (SUBBYTES_BYPASS_EN defined): send in_bypass=1, in_data=32'h0011_2233 -> out_data=32'h0011_2233, out_bypass=1; the next beat with bypass=0 is substituted normally.

Source files
------------

// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes: forward or inverse S-box on LANES bytes per beat, valid/ready with full backpressure.
// Define SUBBYTES_BYPASS_EN to add a per-beat bypass (in_bypass/out_bypass) that passes data through unchanged.
module sub_bytes_pipe #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_inv,
  input  logic [8*LANES-1:0]          in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_inv,
  output logic [8*LANES-1:0]          out_data,
`ifdef SUBBYTES_BYPASS_EN
  input  logic                        in_bypass,
  output logic                        out_bypass,
`endif
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int unsigned W     = 8 * LANES;
  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  // FIPS-197 tables, byte 0x00 in the most significant position.
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [10:0] idx;
    idx = {~b, 3'b000};  // 8*(255-b)
    if (inv) sub_byte = INV_TBL[idx +: 8];
    else     sub_byte = FWD_TBL[idx +: 8];
  endfunction

  logic             in_fire;
  logic             out_fire;
  logic             load_out;
  logic             in_byp;
  logic [W-1:0]     lk_data;
  logic             lk_inv;
  logic             lk_byp;
  logic [W-1:0]     out_data_d;
  logic             out_valid_q;
  logic             out_inv_q;
  logic [W-1:0]     out_data_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

`ifdef SUBBYTES_BYPASS_EN
  assign in_byp = in_bypass;
`else
  assign in_byp = 1'b0;
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  if (STAGES == 2) begin : g_two
    logic         s0_valid_q;
    logic [W-1:0] s0_data_q;
    logic         s0_inv_q;
    logic         s0_byp_q;
    logic         s0_adv;

    // Stage 0 moves on when the output register is empty or draining this cycle.
    assign s0_adv   = s0_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !rst && (!s0_valid_q || s0_adv);
    assign load_out = s0_adv;
    assign lk_data  = s0_data_q;
    assign lk_inv   = s0_inv_q;
    assign lk_byp   = s0_byp_q;

    always_ff @(posedge clk) begin
      if (rst)          s0_valid_q <= 1'b0;
      else if (in_fire) s0_valid_q <= 1'b1;
      else if (s0_adv)  s0_valid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (in_fire) begin
        s0_data_q <= in_data;
        s0_inv_q  <= in_inv;
        s0_byp_q  <= in_byp;
      end
    end
  end else begin : g_one
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign load_out = in_fire;
    assign lk_data  = in_data;
    assign lk_inv   = in_inv;
    assign lk_byp   = in_byp;
  end

  // Per-lane substitution feeding the output register.
  always_comb begin
    out_data_d = lk_data;
    if (!lk_byp) begin
      for (int k = 0; k < int'(LANES); k++) begin
        out_data_d[8*k +: 8] = sub_byte(lk_data[8*k +: 8], lk_inv);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inv_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_inv_q   <= lk_inv;
      out_data_q  <= out_data_d;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef SUBBYTES_BYPASS_EN
  logic out_byp_q;

  always_ff @(posedge clk) begin
    if (rst)           out_byp_q <= 1'b0;
    else if (load_out) out_byp_q <= lk_byp;
  end

  assign out_bypass = out_byp_q;
`endif

  assign occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign out_valid = out_valid_q;
  assign out_inv   = out_inv_q;
  assign out_data  = out_data_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: a LANES=4/STAGES=2 instance and a LANES=16/STAGES=1 instance,
// checked against S-box tables derived from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_sub_bytes_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_in_valid, a_in_ready, a_in_inv;
  logic [31:0]  a_in_data;
  logic         a_out_valid, a_out_ready, a_out_inv;
  logic [31:0]  a_out_data;
  logic [1:0]   a_occ;

  logic         b_in_valid, b_in_ready, b_in_inv;
  logic [127:0] b_in_data;
  logic         b_out_valid, b_out_ready, b_out_inv;
  logic [127:0] b_out_data;
  logic [0:0]   b_occ;

`ifdef SUBBYTES_BYPASS_EN
  logic a_in_byp, a_out_byp, b_in_byp, b_out_byp;
`endif

  sub_bytes_pipe #(.LANES(4), .STAGES(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_inv    (a_in_inv),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_inv   (a_out_inv),
    .out_data  (a_out_data),
`ifdef SUBBYTES_BYPASS_EN
    .in_bypass (a_in_byp),
    .out_bypass(a_out_byp),
`endif
    .occupancy (a_occ)
  );

  sub_bytes_pipe #(.LANES(16), .STAGES(1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_inv    (b_in_inv),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_inv   (b_out_inv),
    .out_data  (b_out_data),
`ifdef SUBBYTES_BYPASS_EN
    .in_bypass (b_in_byp),
    .out_bypass(b_out_byp),
`endif
    .occupancy (b_occ)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference S-box built from the field inverse and affine map.
  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv,
                                         input logic byp, input int lanes);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      if (byp)      r[8*k +: 8] = d[8*k +: 8];
      else if (inv) r[8*k +: 8] = inv_m[d[8*k +: 8]];
      else          r[8*k +: 8] = fwd_m[d[8*k +: 8]];
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        inv;
    logic        byp;
  } beat_t;

  beat_t       exp_q[$];
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_inv;

  // Scoreboard for instance A: order, content, occupancy and stall stability.
  always @(negedge clk) begin
    beat_t e;
    logic  byp_i, byp_o;
`ifdef SUBBYTES_BYPASS_EN
    byp_i = a_in_byp;
    byp_o = a_out_byp;
`else
    byp_i = 1'b0;
    byp_o = 1'b0;
`endif
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("a_occupancy", 128'(a_occ), 128'(exp_q.size()));
      if (prev_stall) begin
        check("a_stall_valid", 128'(a_out_valid), 128'h1);
        check("a_stall_data", 128'(a_out_data), 128'(prev_data));
        check("a_stall_inv", 128'(a_out_inv), 128'(prev_inv));
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          check("a_spurious_out", 128'h1, 128'h0);
        end else begin
          e = exp_q.pop_front();
          check("a_out_data", 128'(a_out_data), 128'(e.data));
          check("a_out_inv", 128'(a_out_inv), 128'(e.inv));
          check("a_out_bypass", 128'(byp_o), 128'(e.byp));
        end
      end
      if (a_in_valid && a_in_ready) begin
        e.data = 32'(model(128'(a_in_data), a_in_inv, byp_i, 4));
        e.inv  = a_in_inv;
        e.byp  = byp_i;
        exp_q.push_back(e);
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
      prev_inv   = a_out_inv;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] sweep_data(input int m);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * m + k);
    return d;
  endfunction

  int           acc;
  logic         fire;
  logic [127:0] cur;
  logic         cinv;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
`ifdef SUBBYTES_BYPASS_EN
    a_in_byp = 1'b0; b_in_byp = 1'b0;
`endif
    for (int i = 0; i < 256; i++) fwd_m[i] = affine(ginv(8'(i)));
    for (int i = 0; i < 256; i++) inv_m[fwd_m[i]] = 8'(i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_valid", 128'(a_out_valid), 128'h0);
    check("rst_a_data", 128'(a_out_data), 128'h0);
    check("rst_a_inv", 128'(a_out_inv), 128'h0);
    check("rst_a_occ", 128'(a_occ), 128'h0);
    check("rst_a_ready", 128'(a_in_ready), 128'h1);
    check("rst_b_valid", 128'(b_out_valid), 128'h0);
    check("rst_b_data", 128'(b_out_data), 128'h0);
    check("rst_b_occ", 128'(b_occ), 128'h0);

    // Forward beat, latency 2.
    step();
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = 32'hfa655600;
    step();
    a_in_valid = 1'b0;
    @(negedge clk);
    check("fwd_early_valid", 128'(a_out_valid), 128'h0);
    step(); @(negedge clk);
    check("fwd_valid", 128'(a_out_valid), 128'h1);
    check("fwd_data", 128'(a_out_data), 128'h2d4db163);
    check("fwd_inv", 128'(a_out_inv), 128'h0);
    step(); @(negedge clk);
    check("fwd_occ_empty", 128'(a_occ), 128'h0);

    // Inverse beat.
    step();
    a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_data = 32'h2d4db163;
    step();
    a_in_valid = 1'b0;
    step(); @(negedge clk);
    check("inv_valid", 128'(a_out_valid), 128'h1);
    check("inv_data", 128'(a_out_data), 128'hfa655600);
    check("inv_inv", 128'(a_out_inv), 128'h1);
    step(); step();

    // Back-to-back mixed stream at one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        a_in_valid = 1'b1; a_in_inv = 1'(i); a_in_data = 32'($urandom);
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8)  check("mix_in_ready", 128'(a_in_ready), 128'h1);
      if (i >= 2) check("mix_out_valid", 128'(a_out_valid), 128'h1);
      step();
    end

    // Backpressure: only STAGES beats fit.
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_inv = 1'($urandom); a_in_data = 32'($urandom); acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); fire = a_in_ready;
      step();
      if (fire) begin
        acc++; a_in_inv = 1'($urandom); a_in_data = 32'($urandom);
      end
    end
    check("bp_accepted", 128'(acc), 128'h2);
    @(negedge clk);
    check("bp_in_ready", 128'(a_in_ready), 128'h0);
    check("bp_occ", 128'(a_occ), 128'h2);
    check("bp_out_valid", 128'(a_out_valid), 128'h1);
    step();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("bp_drained", 128'(exp_q.size()), 128'h0);

    // Reset with the pipe full; offered beat during reset is dropped.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'($urandom);
    for (int i = 0; i < 4; i++) begin
      step(); a_in_data = 32'($urandom);
    end
    @(negedge clk);
    check("rst_full_occ", 128'(a_occ), 128'h2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 128'(a_out_valid), 128'h0);
    check("rst_mid_occ", 128'(a_occ), 128'h0);
    check("rst_mid_ready", 128'(a_in_ready), 128'h1);
    a_out_ready = 1'b1;
    repeat (5) step();

`ifdef SUBBYTES_BYPASS_EN
    // Bypass beat then a substituted beat.
    a_in_valid = 1'b1; a_in_byp = 1'b1; a_in_inv = 1'b1; a_in_data = 32'h00112233;
    step();
    a_in_byp = 1'b0; a_in_inv = 1'b0;
    step();
    a_in_valid = 1'b0;
    @(negedge clk);
    check("byp_data", 128'(a_out_data), 128'h00112233);
    check("byp_flag", 128'(a_out_byp), 128'h1);
    step(); @(negedge clk);
    check("byp_next_data", 128'(a_out_data), 128'h638293c3);
    check("byp_next_flag", 128'(a_out_byp), 128'h0);
    repeat (2) step();
`endif

    // Randomized traffic with random backpressure; upstream holds until accepted.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); fire = a_in_valid && a_in_ready;
      step();
      if (!a_in_valid || fire) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_in_inv   = 1'($urandom);
        a_in_data  = 32'($urandom);
`ifdef SUBBYTES_BYPASS_EN
        a_in_byp   = ($urandom_range(0, 7) == 0);
`endif
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("rand_drained", 128'(exp_q.size()), 128'h0);

    // Instance B: all 256 byte values in both modes, latency 1, back to back.
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = sweep_data(0);
    for (int j = 0; j < 32; j++) begin
      cur = b_in_data; cinv = b_in_inv;
      step();
      if (j < 31) begin
        b_in_inv = (j + 1 >= 16); b_in_data = sweep_data((j + 1) % 16);
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      check("b_valid", 128'(b_out_valid), 128'h1);
      check("b_data", b_out_data, model(cur, cinv, 1'b0, 16));
      check("b_inv", 128'(b_out_inv), 128'(cinv));
      if (j == 0)  check("b_fwd_00", 128'(b_out_data[7:0]), 128'h63);
      if (j == 15) check("b_fwd_ff", 128'(b_out_data[127:120]), 128'h16);
      if (j == 17) check("b_inv_16", 128'(b_out_data[55:48]), 128'hff);
      if (j == 22) check("b_inv_63", 128'(b_out_data[31:24]), 128'h00);
    end
    step(); @(negedge clk);
    check("b_idle_valid", 128'(b_out_valid), 128'h0);
    check("b_idle_occ", 128'(b_occ), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
